// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register map, status bits and FSM encoding for uart_tx_mmio
package uart_pkg;

  // Word offsets within the register window, decoded on addr[3:2]
  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_BAUDDIV = 2'd2;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered head-of-queue output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push_ok, pop_ok;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = dout_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    // Bypass so a byte pushed into an empty slot is visible at the head next cycle
    if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      dout_d = din;
    end else begin
      dout_d = mem_q[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq
);

  tx_state_e   state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic        we, push, pop;
  logic [1:0]  off;
  logic [7:0]  fifo_dout;
  logic        fifo_full, fifo_empty;
  logic        unused_bits;

  assign sel         = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign we          = MemWrite && sel;
  assign off         = Mem_WrAddr[3:2];
  assign push        = we && (off == OFF_TXDATA);
  assign pop         = (state_q == IDLE) && !fifo_empty;
  assign tx          = tx_q;
  assign irq         = fifo_empty && (state_q == IDLE);
  assign unused_bits = ^{Mem_WrData[31:16], Mem_WrAddr[1:0]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (Mem_WrData[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (off)
        OFF_STATUS: begin
          rdata[ST_FULL]  = fifo_full;
          rdata[ST_EMPTY] = fifo_empty;
          rdata[ST_BUSY]  = (state_q != IDLE);
          rdata[ST_OVF]   = ovf_q;
        end
        OFF_BAUDDIV: rdata = {16'b0, div_q};
        default:     rdata = '0;
      endcase
    end
  end

  always_comb begin
    div_d = div_q;
    ovf_d = ovf_q;
    if (we && (off == OFF_BAUDDIV)) begin
      div_d = (Mem_WrData[15:0] == 16'd0) ? 16'd1 : Mem_WrData[15:0];
    end
    if (we && (off == OFF_STATUS)) begin
      ovf_d = 1'b0;
    end else if (push && fifo_full) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d = fifo_dout;
          baud_d  = div_q - 16'd1;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == 16'd0) begin
          baud_d  = div_q - 16'd1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == 16'd0) begin
          shift_d = {1'b0, shift_q[7:1]};
          baud_d  = div_q - 16'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == 16'd0) begin
          state_d = IDLE;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the present state, so the line lags the FSM by one cycle
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= DEFAULT_DIV;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;

  localparam logic [31:0] TXD = 32'h0000_0400;
  localparam logic [31:0] STS = 32'h0000_0404;
  localparam logic [31:0] BDV = 32'h0000_0408;
  localparam logic [31:0] RSV = 32'h0000_040C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Mem_WrAddr = '0;
  logic [31:0] Mem_WrData = '0;
  logic [31:0] rdata;
  logic        sel, tx, irq;

  int checks = 0;
  int errors = 0;

  uart_tx_mmio dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .rdata      (rdata),
    .sel        (sel),
    .tx         (tx),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    Mem_WrAddr = a;
    Mem_WrData = d;
    @(negedge clk);
    MemWrite   = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    Mem_WrAddr = a;
    #1;
    d = rdata;
  endtask

  logic [31:0] rd;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_bytes[$];
  int          exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
  int          exp_5a[10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd1);
    check("rst_sel_off", {31'b0, sel}, 32'd0);
    bus_rd(STS, rd);    check("rst_status", rd, 32'h0000_0002);
    bus_rd(BDV, rd);    check("rst_bauddiv", rd, 32'd868);
    bus_rd(RSV, rd);    check("rsv_read", rd, 32'd0);
    bus_rd(TXD, rd);    check("txdata_read", rd, 32'd0);
    check("sel_in_window", {31'b0, sel}, 32'd1);
    @(negedge clk);

    // Single frame 0xA5 at div=4
    bus_wr(BDV, 32'd4);
    bus_wr(TXD, 32'h0000_00A5);
    @(negedge clk);
    check("a5_pre_start", {31'b0, tx}, 32'd1);
    check("a5_irq_busy", {31'b0, irq}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check($sformatf("a5_bit%0d_c%0d", i, k), {31'b0, tx}, exp_a5[i]);
      end
    end
    repeat (2) @(negedge clk);
    check("a5_irq_done", {31'b0, irq}, 32'd1);

    // Overflow: one byte in flight, then nine pushes into an 8-deep FIFO
    bus_wr(BDV, 32'd2);
    exp_bytes = '{8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    fork
      begin
        bus_wr(TXD, 32'h3C);
        repeat (3) @(negedge clk);
        for (int i = 1; i <= 9; i++) bus_wr(TXD, 32'(i * 8'h11));
        bus_rd(STS, rd);  check("ovf_status", rd, 32'h0000_000D);
        bus_wr(STS, 32'd0);
        bus_rd(STS, rd);  check("ovf_cleared", rd, 32'h0000_0005);
      end
      begin
        for (int f = 0; f < 9; f++) begin
          int t;
          logic [7:0] b;
          t = 0;
          while (tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
          end
          check($sformatf("rx_start%0d", f), {31'b0, (t < 400)}, 32'd1);
          if (t >= 400) break;
          for (int i = 0; i < 8; i++) begin
            repeat (2) @(negedge clk);
            b[i] = tx;
          end
          repeat (2) @(negedge clk);
          check($sformatf("rx_stop%0d", f), {31'b0, tx}, 32'd1);
          rx_q.push_back(b);
        end
      end
    join
    check("rx_count", rx_q.size(), 32'd9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_bytes[i]});
    begin
      int t;
      t = 0;
      while (irq !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("ovf_irq_done", {31'b0, irq}, 32'd1);
    end
    @(negedge clk);

    // BAUDDIV=0 is stored as 1: one cycle per bit
    bus_wr(BDV, 32'd0);
    bus_rd(BDV, rd);  check("div0_readback", rd, 32'd1);
    bus_wr(TXD, 32'h5A);
    @(negedge clk);
    check("5a_pre_start", {31'b0, tx}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("5a_bit%0d", i), {31'b0, tx}, exp_5a[i]);
    end
    repeat (3) @(negedge clk);
    check("5a_irq_done", {31'b0, irq}, 32'd1);

    // Reset in DATA bit 3 with a second byte queued
    bus_wr(BDV, 32'd4);
    bus_wr(TXD, 32'h00);
    bus_wr(TXD, 32'h77);
    repeat (18) @(negedge clk);
    check("mid_bit3_tx", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_tx", {31'b0, tx}, 32'd1);
    check("mid_rst_irq", {31'b0, irq}, 32'd1);
    bus_rd(STS, rd);  check("mid_rst_status", rd, 32'h0000_0002);
    bus_rd(BDV, rd);  check("mid_rst_bauddiv", rd, 32'd868);
    begin
      logic seen_low;
      seen_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (tx !== 1'b1) seen_low = 1'b1;
      end
      check("mid_rst_no_frame", {31'b0, seen_low}, 32'd0);
    end

    // Store outside the window
    MemWrite   = 1'b1;
    Mem_WrAddr = 32'h0000_0500;
    Mem_WrData = 32'h0000_00AB;
    #1;
    check("oow_sel", {31'b0, sel}, 32'd0);
    check("oow_rdata", rdata, 32'd0);
    @(negedge clk);
    MemWrite = 1'b0;
    bus_rd(STS, rd);  check("oow_status", rd, 32'h0000_0002);
    repeat (5) @(negedge clk);
    check("oow_tx_idle", {31'b0, tx}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
